aes_iter_enc: RTL
=================

# aes_iter_enc

Iterative AES encryption core: one round per clock, parametrised for AES-128 (10 rounds) or AES-256 (14 rounds). It replaces the unrolled first-round datapath with a single shared round datapath, a round counter and valid/ready handshakes on both sides. Round keys come from an external key-schedule store through a combinational index/data lookup port. The block sits between the plaintext source and the ciphertext sink of the encryption path.

## Interface
Parameters:
- KEY_BITS, 128, key size; legal values 128 or 256. Any other value is a elaboration error.
- NR, derived: 10 when KEY_BITS=128, 14 when KEY_BITS=256. Localparam, not overridable.

Ports:
- clk  in  1  clock; all flops on rising edge.
- asy_reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext offered.
- in_ready  out  1  core can accept plaintext.
- pt  in  128  plaintext, byte 0 in [127:120], column-major state.
- rk_idx  out  4  index of the round key needed this cycle (0..NR).
- rk  in  128  round key rk_idx, returned combinationally in the same cycle.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  sink accepts ciphertext.
- ct  out  128  ciphertext; held stable while out_valid=1.
- busy  out  1  high in ROUND or DONE.

## Operation
- States: IDLE, ROUND, DONE. 2-bit state register, 4-bit round counter rnd, 128-bit state register st.
- IDLE: in_ready=1, rk_idx=0. On in_valid&&in_ready: st <= pt ^ rk (initial AddRoundKey), rnd <= 1, go ROUND. pt sampled only at this edge.
- ROUND: rk_idx=rnd. If rnd<NR: st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk, rnd <= rnd+1. If rnd==NR: st <= ShiftRows(SubBytes(st)) ^ rk (no MixColumns), go DONE.
- DONE: out_valid=1, ct=st, rk_idx=0. On out_ready: go IDLE, out_valid falls next cycle. Without out_ready the core stalls indefinitely, ct unchanged.
- in_ready is 1 only in IDLE; in_valid is ignored in ROUND/DONE. No accept in the same cycle as the output handshake.
- out_ready outside DONE is ignored.
- ct is driven from st at all times; only meaningful while out_valid=1.
- Reset (at any time, including mid-ROUND): state=IDLE, rnd=0, st=0. Outputs after reset: in_ready=1, out_valid=0, busy=0, ct=0, rk_idx=0. The in-flight block is discarded with no partial output.
- rk changes while the core is in IDLE without a handshake have no effect.

## Timing
- Latency: accept edge E0. Rounds occur at edges E1..E(NR), DONE is entered at E(NR). out_valid is high from the cycle after E(NR): NR+1 cycles from accept to out_valid (11 for AES-128, 15 for AES-256).
- Minimum block interval with out_ready held at 1: NR+2 cycles (accept, NR rounds, DONE cycle, then back to IDLE).
- rk_idx is a registered-state decode (no combinational path from inputs). rk→st is one combinational round in a single cycle, which is the critical path.
- Sink must tolerate out_valid asserted without waiting on out_ready. Source must hold pt only during its in_valid cycle(s) until accept.

## Structure
- Package aes_pkg: S-box function (256-entry constant), xtime/gf-multiply functions, state/byte typedefs, NR_128=10 and NR_256=14 constants, and FSM state enum.
- One sub-module, aes_round: combinational, with inputs state, rk, and last; output next_state. It performs SubBytes, ShiftRows, conditional MixColumns, and AddRoundKey. The top level holds the FSM, counter and registers only.

## Test plan
- AES-128 FIPS-197 C.1: key 000102…0f, bench model serves rk by rk_idx, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after accept.
- AES-256 FIPS-197 C.3: key 000102…1f, same pt -> ct 8ea2b7ca516745bfeafc49904b496089, out_valid 15 cycles after accept; rk_idx sequence 0,1,…,14.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> ct stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 for one cycle -> IDLE, next block accepted correctly.
- Back-to-back: 8 random blocks with in_valid/out_ready held at 1 -> all match the reference model, interval exactly NR+2 cycles.
- Reset mid-round: assert asy_reset at round 5 -> outputs drop immediately to reset values (ct=0, out_valid=0, in_ready=1). The next block after release encrypts correctly.
- Handshake edges: in_valid asserted with out_ready=1 during DONE -> not accepted until IDLE. out_ready pulses during ROUND -> no effect.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES constants, S-box and GF(2^8) helpers shared by the iterative encryption core
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  localparam int NR_128 = 10;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_t;

  // Entry 0 sits in the top byte so the table reads in natural order.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t sbox(input byte_t b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul3(input byte_t b);
    return xtime(b) ^ b;
  endfunction

  function automatic word_t mix_column(input word_t col);
    byte_t a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ gf_mul3(a2) ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ gf_mul3(a3),
            gf_mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_iter_enc_if.sv
// rtl/aes_iter_enc_if.sv - plaintext/ciphertext handshakes and round-key lookup port of the AES core
interface aes_iter_enc_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct;

  modport master (
    output in_valid, pt, rk, out_ready,
    input  in_ready, rk_idx, out_valid, ct
  );

  modport slave (
    input  in_valid, pt, rk, out_ready,
    output in_ready, rk_idx, out_valid, ct
  );
endinterface

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey
module aes_round
  import aes_pkg::*;
(
  input  state_t state,
  input  state_t rk,
  input  logic   last,
  output state_t next_state
);

  state_t sr;
  state_t mc;

  // Byte (row r, column c) lives at index 4*c+r; row r rotates left by r columns.
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sbox(state[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
  end

  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    end
  end

  assign next_state = (last ? sr : mc) ^ rk;

endmodule

// File: rtl/aes_iter_enc.sv
// rtl/aes_iter_enc.sv - iterative AES-128/256 encryption core, one round per clock
module aes_iter_enc
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic           clk,
  input  logic           asy_reset,
  aes_iter_enc_if.slave  bus,
  output logic           busy
);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_enc: KEY_BITS must be 128 or 256");
  end

  localparam int         NR   = (KEY_BITS == 256) ? NR_256 : NR_128;
  localparam logic [3:0] NR_L = NR[3:0];

  fsm_t       state, state_nxt;
  logic [3:0] rnd, rnd_nxt;
  state_t     st, st_nxt;
  state_t     round_out;

  aes_round u_round (
    .state      (st),
    .rk         (bus.rk),
    .last       (rnd == NR_L),
    .next_state (round_out)
  );

  // Outputs decode registered state only, so rk_idx never depends on inputs.
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.rk_idx    = (state == S_ROUND) ? rnd : 4'd0;
  assign bus.ct        = st;
  assign busy          = (state == S_ROUND) || (state == S_DONE);

  always_ff @(posedge clk or posedge asy_reset) begin
    if (asy_reset) begin
      state <= S_IDLE;
      rnd   <= 4'd0;
      st    <= '0;
    end else begin
      state <= state_nxt;
      rnd   <= rnd_nxt;
      st    <= st_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rnd_nxt   = rnd;
    st_nxt    = st;
    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          st_nxt    = bus.pt ^ bus.rk;
          rnd_nxt   = 4'd1;
          state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        st_nxt = round_out;
        if (rnd == NR_L) begin
          state_nxt = S_DONE;
        end else begin
          rnd_nxt = rnd + 4'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
